irq_arbiter: RTL

Priority interrupt arbiter between the board interrupt sources and the pipelined CPU. Sources include the timer, the button external interrupt and spare lines. The block latches source request edges into pending bits and masks them with a software-writable enable register. It selects one winner, presents it to the CPU as a single level request with an ID, and sequences a claim/complete handshake that returns per-source acknowledges. It sits between the source modules and the CPU interrupt interface. Its register window is reached through the memory-mapped I/O bus.

---
 rtl/irq_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches source request edges into pending bits, masks them with
// a software enable register, and presents one winner to the CPU through a
// claim/complete handshake that returns a one-cycle per-source acknowledge.
// Optional build macro IRQ_ROUND_ROBIN_EN: round-robin winner selection with a
// pointer that moves past each claimed source. Undefined: fixed priority, index 0 highest.
module irq_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    output logic [NUM_SRC-1:0] src_ack,
    output logic               cpu_irq,
    output logic [ID_W-1:0]    cpu_irq_id,
    input  logic               cpu_claim,
    input  logic               cpu_complete,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] set_bits, clr_bits;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] wdata_src;
    logic [NUM_SRC-1:0] scan_bits;
    logic [NUM_SRC-1:0] src_ack_q;
    logic [ID_W-1:0]    cur_id_q;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cpu_irq_id_q;
    logic               cpu_irq_q;
    logic               win_found;
    logic               claim_fire;
    logic               we_en, we_pend, we_swtrig;
    logic [31:0]        rdata_q, rdata_d;
    int                 scan_idx;
    logic               unused_bits;
`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]    rr_ptr_q;
`endif

    assign cand       = pend_q & en_q;
    assign wdata_src  = reg_wdata[NUM_SRC-1:0];
    assign we_en      = reg_we && (reg_addr[3:2] == 2'd0);
    assign we_pend    = reg_we && (reg_addr[3:2] == 2'd1);
    assign we_swtrig  = reg_we && (reg_addr[3:2] == 2'd3);
    assign claim_mask = NUM_SRC'(1) << win_id;
    assign claim_fire = (state_q == ST_REQ) && cpu_claim && win_found;

    // Sets (edge, SWTRIG) are applied after clears (W1C, claim) so a set wins.
    assign set_bits = (src_req & ~req_q) | (we_swtrig ? wdata_src : '0);
    assign clr_bits = (we_pend ? wdata_src : '0) | (claim_fire ? claim_mask : '0);
    assign pend_d   = (pend_q & ~clr_bits) | set_bits;
    assign en_d     = we_en ? wdata_src : en_q;

    assign unused_bits = ^{reg_wdata[31:NUM_SRC], reg_addr[1:0]};

    assign src_ack    = src_ack_q;
    assign cpu_irq    = cpu_irq_q;
    assign cpu_irq_id = cpu_irq_id_q;
    assign reg_rdata  = rdata_q;

    // Winner search: first candidate from the scan start, upward with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        scan_bits = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef IRQ_ROUND_ROBIN_EN
            scan_idx = (int'(rr_ptr_q) + k) % NUM_SRC;
`else
            scan_idx = k;
`endif
            scan_bits = cand >> scan_idx;
            if (!win_found && scan_bits[0]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    // Read mux for the register window, registered below.
    always_comb begin
        rdata_d = '0;
        case (reg_addr[3:2])
            2'd0: rdata_d[NUM_SRC-1:0] = en_q;
            2'd1: rdata_d[NUM_SRC-1:0] = pend_q;
            2'd2: begin
                rdata_d[8]        = (state_q == ST_SERVICE);
                rdata_d[5:4]      = state_q;
                rdata_d[ID_W-1:0] = cur_id_q;
            end
            default: rdata_d = '0;
        endcase
    end

    // Previous-cycle copy of the requests; it keeps sampling during reset so a
    // source already high when reset releases is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        req_q <= src_req;
    end

    // Pending, enable and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            en_q    <= '0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
        end
    end

    // Handshake FSM with registered CPU-side outputs and acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cpu_irq_q    <= 1'b0;
            cpu_irq_id_q <= '0;
            src_ack_q    <= '0;
            cur_id_q     <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            src_ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q      <= ST_REQ;
                        cpu_irq_q    <= 1'b1;
                        cpu_irq_id_q <= win_id;
                    end
                end
                ST_REQ: begin
                    if (!win_found) begin
                        state_q   <= ST_IDLE;
                        cpu_irq_q <= 1'b0;
                    end else if (cpu_claim) begin
                        state_q      <= ST_SERVICE;
                        cpu_irq_q    <= 1'b0;
                        cpu_irq_id_q <= win_id;
                        cur_id_q     <= win_id;
                        src_ack_q    <= claim_mask;
`ifdef IRQ_ROUND_ROBIN_EN
                        rr_ptr_q     <= ID_W'((int'(win_id) + 1) % NUM_SRC);
`endif
                    end else begin
                        cpu_irq_id_q <= win_id;
                    end
                end
                ST_SERVICE: begin
                    if (cpu_complete) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cpu_irq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
